seq_detector_param: RTL

- Parametrised serial bit-pattern detector; successor to the fixed 4-bit "1010" Mealy detector.
- Generalised to any pattern width, with a runtime-loadable pattern and a selectable overlap/non-overlap mode.
- Adds an input-enable, a registered match output and a saturating match counter.
- Sits on a serial input stream and flags each completed occurrence of the pattern.

---
 rtl/seq_detector_param.sv | 84 ++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector with loadable pattern
// Mealy match flag, registered copy and saturating match counter over an enabled bit stream.
module seq_detector_param #(
  parameter int              PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             out,
  output logic             out_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int             FW       = $clog2(PAT_W);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] pat_reg;
  logic [PAT_W-2:0] hist;
  logic [PAT_W-2:0] hist_shift;
  logic [FW-1:0]    fill;
  logic             match_now;

  // A 2-bit pattern keeps a single history bit, so there is nothing to shift along.
  generate
    if (PAT_W == 2) begin : g_shift_one
      assign hist_shift = in;
    end else begin : g_shift_many
      assign hist_shift = {hist[PAT_W-3:0], in};
    end
  endgenerate

  // fill gating stops an all-zero pattern from matching the cleared history.
  assign match_now = en & ~pat_load & (fill == FILL_MAX) & ({hist, in} == pat_reg);
  assign out       = match_now;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_reg <= PATTERN;
      hist    <= '0;
      fill    <= '0;
    end else if (pat_load) begin
      pat_reg <= pat_in;
      hist    <= '0;
      fill    <= '0;
    end else if (en) begin
      if (match_now && !overlap) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= hist_shift;
        if (fill != FILL_MAX) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= 1'b0;
    end else begin
      out_q <= match_now;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (match_now && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule
